// File: rtl/poly_msg_add_pkg.sv
// poly_msg_add_pkg
// Shared Kyber constants for the polynomial message-add stage and its
// modular adder. The KYBER_* macros are guarded so that a project-wide
// params header defining them first takes precedence over these values.
//   N      : coefficients per polynomial
//   W      : coefficient width in bits
//   Q      : Kyber modulus
//   IDX_W  : width of the coefficient index counter
//   MSG_W  : width of a flattened polynomial (N*W bits)

`ifndef KYBER_N
`define KYBER_N 256
`endif
`ifndef KYBER_R_WIDTH
`define KYBER_R_WIDTH 12
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

package poly_msg_add_pkg;

  localparam int N     = `KYBER_N;
  localparam int W     = `KYBER_R_WIDTH;
  localparam int Q     = `KYBER_Q;
  localparam int IDX_W = 8;
  localparam int MSG_W = N * W;

  // Index value of the final coefficient of a pass.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

endpackage

// File: rtl/mod_add_q.sv
// mod_add_q
// Combinational modular adder: sum = (a + b) mod Q.
// Both operands must already be reduced (< Q), so one conditional
// subtraction of Q is enough to bring the result back into range.
// Ports:
//   a, b : W-bit reduced operands
//   sum  : W-bit reduced result

module mod_add_q
  import poly_msg_add_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] raw;

  // One extra bit holds the carry so a+b never wraps before the compare.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= (W+1)'(Q)) begin
      sum = W'(raw - (W+1)'(Q));
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/poly_msg_add.sv
// poly_msg_add
// Adds a decoded message polynomial m (coefficients 0 or 1665) to a
// streamed polynomial v, one coefficient per cycle, producing
// (v_i + m_i) mod Q with a one-cycle registered latency.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : latch poly_msg and begin a pass (honoured only when idle)
//   poly_msg   : N*W message polynomial, coefficient i at [i*W +: W]
//   in_valid   : in_coeff present
//   in_coeff   : coefficient of v, index order 0..N-1
//   in_ready   : block accepts in_coeff this cycle
//   out_valid  : out_coeff valid
//   out_coeff  : (in_coeff + m_i) mod Q
//   out_last   : marks the final coefficient of the pass
//   out_ready  : downstream accepts out_coeff
//   busy       : a pass is in progress
//   done       : one-cycle pulse after the last coefficient leaves

module poly_msg_add
  import poly_msg_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MSG_W-1:0] poly_msg,
  input  logic             in_valid,
  input  logic [W-1:0]     in_coeff,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_coeff,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t           state;
  logic [MSG_W-1:0] msg_reg;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     m_coeff;
  logic [W-1:0]     sum;
  logic             in_xfer;
  logic             out_xfer;

  // The message is read from the latched copy so that poly_msg may change
  // freely once a pass has started.
  assign m_coeff = msg_reg[int'(idx) * W +: W];

  mod_add_q u_mod_add_q (
    .a   (in_coeff),
    .b   (m_coeff),
    .sum (sum)
  );

  // The output register can take a new value when empty or when it is
  // being drained this same cycle; in_valid never feeds back into ready.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign busy     = (state != IDLE);

  // Control FSM and the single-entry output register. A new input transfer
  // overrides the drain of the previous output, which is what lets a
  // back-to-back stream run at one coefficient per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      msg_reg   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_coeff <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            msg_reg <= poly_msg;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (in_xfer) begin
            out_coeff <= sum;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            idx       <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= FLUSH;
            end
          end else if (out_xfer) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          // Only the final coefficient is left to drain; no new input.
          if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_msg_add.sv
// tb_poly_msg_add
// Self-checking bench for poly_msg_add: reset values, a table of
// hand-computed coefficient sums, the modulus boundary, backpressure,
// ignored mid-pass control and an asynchronous reset in the middle of a pass.

module tb_poly_msg_add;
  import poly_msg_add_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [MSG_W-1:0] poly_msg;
  logic             in_valid;
  logic [W-1:0]     in_coeff;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_coeff;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [W-1:0] coeffs  [N];
  logic [W-1:0] exp_out [N];
  bit   [N-1:0] msg_bits;

  typedef struct {
    int           idx;
    logic [W-1:0] coeff;
    bit           mbit;
    logic [W-1:0] expv;
  } vec_t;

  vec_t vecs [15];

  poly_msg_add dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .poly_msg  (poly_msg),
    .in_valid  (in_valid),
    .in_coeff  (in_coeff),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_coeff (out_coeff),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Guards against a stalled design never reaching the summary.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [MSG_W-1:0] expand(input bit [N-1:0] bits);
    logic [MSG_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = bits[i] ? W'(1665) : W'(0);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_sum(input int c, input bit m);
    return W'((c + (m ? 1665 : 0)) % Q);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pulses start with the given message; returns one cycle later.
  task automatic applyStimulus(input bit [N-1:0] bits);
    poly_msg = expand(bits);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  // Streams coeffs[] through the block and compares against exp_out[].
  // stall_at : output index at which out_ready drops for 10 cycles (-1 none)
  // ctrl_at  : input index at which start is pulsed and poly_msg changed
  // rst_at   : input index at which rst is raised and the pass abandoned
  task automatic stream(input int stall_at, input int ctrl_at,
                        input int rst_at, input bit [N-1:0] alt_bits);
    int           in_cnt     = 0;
    int           out_cnt    = 0;
    int           cyc        = 0;
    int           stall_left = 0;
    int           done_cnt   = 0;
    bit           stall_done = 1'b0;
    bit           ctrl_done  = 1'b0;
    bit           held_ok    = 1'b0;
    logic [W-1:0] held       = '0;
    while (out_cnt < N) begin
      if (cyc > 2000) begin
        checkOutput("stream_timeout", out_cnt, N);
        break;
      end
      if (done) done_cnt++;
      if (rst_at >= 0 && in_cnt == rst_at) begin
        checkOutput("pre_rst_out_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_coeff", out_coeff, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        return;
      end
      in_valid = (in_cnt < N);
      in_coeff = (in_cnt < N) ? coeffs[in_cnt] : '0;
      if (!stall_done && stall_at >= 0 && out_cnt == stall_at && out_valid) begin
        stall_left = 10;
        stall_done = 1'b1;
      end
      out_ready = (stall_left == 0);
      start = 1'b0;
      if (ctrl_at >= 0 && in_cnt == ctrl_at && !ctrl_done) begin
        start     = 1'b1;
        poly_msg  = expand(alt_bits);
        ctrl_done = 1'b1;
      end
      #1;
      if (stall_left > 0) begin
        checkOutput("stall_in_ready", in_ready, 0);
        if (held_ok) checkOutput("stall_hold", out_coeff, held);
        held    = out_coeff;
        held_ok = 1'b1;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        checkOutput($sformatf("out[%0d]", out_cnt), out_coeff, exp_out[out_cnt]);
        checkOutput($sformatf("out_last[%0d]", out_cnt), out_last, (out_cnt == N-1));
        out_cnt++;
      end
      if (in_valid && in_ready) in_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("done_after_last", done, 1);
    checkOutput("busy_after_last", busy, 0);
    if (done) done_cnt++;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checkOutput("done_once", done_cnt, 1);
    checkOutput("pass_cycles", cyc, 257 + ((stall_at >= 0) ? 10 : 0));
  endtask

  // Random message and coefficients with the reference sums.
  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      msg_bits[i] = 1'($urandom_range(0, 1));
      coeffs[i]   = W'($urandom_range(0, Q - 1));
      exp_out[i]  = ref_sum(int'(coeffs[i]), msg_bits[i]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    poly_msg  = '0;
    in_valid  = 1'b0;
    in_coeff  = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out_coeff", out_coeff, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ordering and arithmetic table; unlisted indices carry coeff=i, m=0.
    vecs = '{
      '{0,   12'd0,    1'b0, 12'd0},
      '{1,   12'd1,    1'b1, 12'd1666},
      '{2,   12'd2,    1'b0, 12'd2},
      '{3,   12'd3,    1'b1, 12'd1668},
      '{4,   12'd4,    1'b0, 12'd4},
      '{5,   12'd5,    1'b0, 12'd5},
      '{6,   12'd6,    1'b0, 12'd6},
      '{7,   12'd7,    1'b1, 12'd1672},
      '{10,  12'd3328, 1'b1, 12'd1664},
      '{11,  12'd1664, 1'b1, 12'd0},
      '{12,  12'd1663, 1'b1, 12'd3328},
      '{13,  12'd3328, 1'b0, 12'd3328},
      '{14,  12'd0,    1'b1, 12'd1665},
      '{15,  12'd1665, 1'b1, 12'd1},
      '{255, 12'd255,  1'b1, 12'd1920}
    };
    msg_bits = '0;
    for (int i = 0; i < N; i++) begin
      coeffs[i]  = W'(i);
      exp_out[i] = W'(i);
    end
    for (int v = 0; v < 15; v++) begin
      coeffs[vecs[v].idx]   = vecs[v].coeff;
      msg_bits[vecs[v].idx] = vecs[v].mbit;
      exp_out[vecs[v].idx]  = vecs[v].expv;
    end
    applyStimulus(msg_bits);
    stream(-1, -1, -1, '0);

    // Modulus boundary: 1664+1665 lands exactly on Q and wraps to 0,
    // 1665+1665 wraps to 1.
    msg_bits = '1;
    for (int i = 0; i < N; i++) begin
      coeffs[i]  = (i % 2 == 0) ? 12'd1664 : 12'd1665;
      exp_out[i] = (i % 2 == 0) ? 12'd0 : 12'd1;
    end
    applyStimulus(msg_bits);
    stream(-1, -1, -1, '0);

    // Backpressure at output index 100
    fill_random();
    applyStimulus(msg_bits);
    stream(100, -1, -1, '0);

    // Start pulse and message change at input index 50 are ignored
    fill_random();
    applyStimulus(msg_bits);
    stream(-1, 50, -1, ~msg_bits);

    // Asynchronous reset at input index 128, then a clean full pass
    fill_random();
    applyStimulus(msg_bits);
    stream(-1, -1, 128, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(msg_bits);
    stream(-1, -1, -1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
